// File: rtl/vertex_transform_sequencer_if.sv
// Vertex RAM port and transformation-datapath handshake bundle for the vertex transform sequencer.
// The sequencer drives the master modport; the RAM/datapath side uses the slave modport.
interface vertex_transform_sequencer_if #(
    parameter int ADDR_W  = 7,
    parameter int COORD_W = 16
);
    logic                   mem_rd_en;
    logic [ADDR_W-1:0]      mem_rd_addr;
    logic [3*COORD_W-1:0]   mem_rd_data;
    logic                   mem_wr_en;
    logic [ADDR_W-1:0]      mem_wr_addr;
    logic [3*COORD_W-1:0]   mem_wr_data;
    logic [3*COORD_W-1:0]   xf_disp;
    logic [3*COORD_W-1:0]   xf_angle;
    logic                   xf_in_valid;
    logic                   xf_in_ready;
    logic [3*COORD_W-1:0]   xf_in_data;
    logic                   xf_out_valid;
    logic                   xf_out_ready;
    logic [3*COORD_W-1:0]   xf_out_data;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output xf_disp, xf_angle,
        output xf_in_valid, xf_in_data,
        input  xf_in_ready,
        input  xf_out_valid, xf_out_data,
        output xf_out_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  xf_disp, xf_angle,
        input  xf_in_valid, xf_in_data,
        output xf_in_ready,
        output xf_out_valid, xf_out_data,
        input  xf_out_ready
    );
endinterface

// File: rtl/vertex_transform_sequencer.sv
// Walks the vertex RAM one vertex at a time, pushes each vertex through the transform
// datapath and writes the result back in place; parameters are frozen for the whole pass.
module vertex_transform_sequencer #(
    parameter int N_VERTS = 100,
    parameter int ADDR_W  = 7,
    parameter int CNT_W   = 7,
    parameter int COORD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [CNT_W-1:0]     i_vert_count,
    input  logic [3*COORD_W-1:0] i_disp,
    input  logic [3*COORD_W-1:0] i_angle,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_aborted,
    vertex_transform_sequencer_if.master bus
);

    localparam int VW = 3 * COORD_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N_VERTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_XF,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_idx;
    logic [VW-1:0]      r_disp;
    logic [VW-1:0]      r_angle;
    logic [VW-1:0]      r_xf_in;
    logic [VW-1:0]      r_result;
    logic               r_err_flag;
    logic               r_done;
    logic               r_err;
    logic               r_aborted;

    logic               w_kill;
    logic               w_start_ok;
    logic               w_cnt_bad;
    logic               w_cnt_zero;
    logic               w_last;
    logic               w_in_valid;
    logic               w_in_fire;
    logic               w_out_fire;

    // Abort only matters once a pass is running; in IDLE it also vetoes a coincident start.
    assign w_kill     = i_abort && (r_state != S_IDLE);
    assign w_start_ok = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_cnt_bad  = i_vert_count > MAX_CNT;
    assign w_cnt_zero = (i_vert_count == '0);
    assign w_last     = (CNT_W'(r_idx) == (r_count - CNT_W'(1)));
    assign w_in_valid = (r_state == S_ISSUE) && !i_abort;
    assign w_in_fire  = w_in_valid && bus.xf_in_ready;
    assign w_out_fire = (r_state == S_WAIT_XF) && !i_abort && bus.xf_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_kill) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        w_next = (w_cnt_zero || w_cnt_bad) ? S_DONE : S_READ;
                    end
                end
                S_READ:    w_next = S_WAIT_RD;
                S_WAIT_RD: w_next = S_ISSUE;
                S_ISSUE: begin
                    if (w_in_fire) begin
                        w_next = S_WAIT_XF;
                    end
                end
                S_WAIT_XF: begin
                    if (w_out_fire) begin
                        w_next = S_WRITE;
                    end
                end
                S_WRITE:   w_next = w_last ? S_DONE : S_READ;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Pass configuration, vertex index and the two vertex holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_idx      <= '0;
            r_disp     <= '0;
            r_angle    <= '0;
            r_xf_in    <= '0;
            r_result   <= '0;
            r_err_flag <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_count    <= i_vert_count;
                r_disp     <= i_disp;
                r_angle    <= i_angle;
                r_err_flag <= w_cnt_bad;
                r_idx      <= '0;
            end
            if (r_state == S_WAIT_RD) begin
                r_xf_in <= bus.mem_rd_data;
            end
            if (w_out_fire) begin
                r_result <= bus.xf_out_data;
            end
            if ((r_state == S_WRITE) && !i_abort && !w_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
        end
    end

    // Completion pulses land the cycle after DONE/abort, when the FSM is already back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= (r_state == S_DONE) && !i_abort;
            r_err     <= (r_state == S_DONE) && !i_abort && r_err_flag;
            r_aborted <= w_kill;
        end
    end

    assign bus.mem_rd_en    = (r_state == S_READ);
    assign bus.mem_rd_addr  = r_idx;
    assign bus.mem_wr_en    = (r_state == S_WRITE) && !i_abort;
    assign bus.mem_wr_addr  = r_idx;
    assign bus.mem_wr_data  = r_result;
    assign bus.xf_disp      = r_disp;
    assign bus.xf_angle     = r_angle;
    assign bus.xf_in_valid  = w_in_valid;
    assign bus.xf_in_data   = r_xf_in;
    assign bus.xf_out_ready = (r_state == S_WAIT_XF) && !i_abort;

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_aborted = r_aborted;

endmodule

// File: tb/tb_vertex_transform_sequencer.sv
// Directed bench for vertex_transform_sequencer: RAM and adder-datapath models plus scenario tasks.
module tb_vertex_transform_sequencer;

    localparam int AW    = 7;
    localparam int CW    = 7;
    localparam int COORD = 16;
    localparam int VW    = 3 * COORD;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [CW-1:0] vcount = '0;
    logic [VW-1:0] disp = '0;
    logic [VW-1:0] angle = '0;
    logic busy, done, err, aborted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vertex_transform_sequencer_if #(.ADDR_W(AW), .COORD_W(COORD)) bus ();

    vertex_transform_sequencer #(.N_VERTS(100), .ADDR_W(AW), .CNT_W(CW), .COORD_W(COORD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_vert_count (vcount),
        .i_disp       (disp),
        .i_angle      (angle),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_aborted    (aborted),
        .bus          (bus.master)
    );

    // Vertex RAM: one-cycle read latency; DUT writes are logged, not stored.
    logic [VW-1:0] ram [0:127];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];
    end

    function automatic logic [VW-1:0] add3(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int k = 0; k < 3; k++) r[k*COORD +: COORD] = a[k*COORD +: COORD] + b[k*COORD +: COORD];
        return r;
    endfunction

    // Datapath model: result = vertex + xf_disp, ready after ready_delay stall cycles,
    // result valid out_delay cycles after the input handshake.
    int ready_delay = 0;
    int out_delay = 0;
    int rdy_wait;
    int dp_cnt;
    logic dp_pend;
    logic ov;
    logic [VW-1:0] dp_res;
    assign bus.xf_in_ready  = (rdy_wait >= ready_delay);
    assign bus.xf_out_valid = ov;
    assign bus.xf_out_data  = dp_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_wait <= 0; dp_cnt <= 0; dp_pend <= 1'b0; ov <= 1'b0; dp_res <= '0;
        end else begin
            if (bus.xf_in_valid && !bus.xf_in_ready) rdy_wait <= rdy_wait + 1;
            else rdy_wait <= 0;
            if (bus.xf_in_valid && bus.xf_in_ready) begin
                dp_pend <= 1'b1;
                dp_res  <= add3(bus.xf_in_data, bus.xf_disp);
                if (out_delay == 0) ov <= 1'b1;
                else dp_cnt <= out_delay;
            end else if (dp_pend && !ov) begin
                if (dp_cnt == 1) ov <= 1'b1;
                dp_cnt <= dp_cnt - 1;
            end
            if (ov && bus.xf_out_ready) begin
                ov <= 1'b0; dp_pend <= 1'b0;
            end
        end
    end

    // Monotonic activity logs sampled on the falling edge.
    int rd_n = 0, wr_n = 0, iss_n = 0, done_n = 0, unstable = 0;
    logic [AW-1:0] rd_log [0:1023];
    logic [AW-1:0] wr_alog [0:1023];
    logic [VW-1:0] wr_dlog [0:1023];
    logic prev_stall = 1'b0;
    logic [VW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (bus.mem_rd_en) begin rd_log[rd_n] = bus.mem_rd_addr; rd_n++; end
        if (bus.mem_wr_en) begin wr_alog[wr_n] = bus.mem_wr_addr; wr_dlog[wr_n] = bus.mem_wr_data; wr_n++; end
        if (prev_stall && bus.xf_in_valid && (bus.xf_in_data !== prev_data)) unstable++;
        if (bus.xf_in_valid && bus.xf_in_ready) iss_n++;
        prev_stall = bus.xf_in_valid && !bus.xf_in_ready;
        prev_data  = bus.xf_in_data;
        if (done) done_n++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] n, input logic [VW-1:0] d, input logic [VW-1:0] a);
        vcount = n; disp = d; angle = a; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            if (done === 1'b1) begin cyc = c; break; end
        end
    endtask

    task automatic test_reset;
        logic [7:0] ctl;
        #1 rst_n = 1'b0;
        #1;
        ctl = {busy, done, err, aborted, bus.mem_rd_en, bus.mem_wr_en, bus.xf_in_valid, bus.xf_out_ready};
        checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl got %h want 00", ctl); end
        checks++; if ({bus.xf_disp, bus.xf_angle, bus.xf_in_data, bus.mem_wr_data} !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", {bus.xf_disp, bus.xf_angle, bus.xf_in_data, bus.mem_wr_data}); end
        checks++; if ({bus.mem_rd_addr, bus.mem_wr_addr} !== '0) begin
            errors++; $display("FAIL reset_addr got %h want 0", {bus.mem_rd_addr, bus.mem_wr_addr}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int cyc, rb, wb;
        logic [VW-1:0] exp_w [0:2];
        exp_w[0] = {16'd11, 16'd12, 16'd13};
        exp_w[1] = {16'd14, 16'd15, 16'd16};
        exp_w[2] = {16'd17, 16'd18, 16'd19};
        ram[0] = {16'd1, 16'd2, 16'd3};
        ram[1] = {16'd4, 16'd5, 16'd6};
        ram[2] = {16'd7, 16'd8, 16'd9};
        rb = rd_n; wb = wr_n;
        do_start(7'd3, {16'd10, 16'd10, 16'd10}, {16'd1, 16'd2, 16'd3});
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        checks++; if (bus.xf_disp !== {16'd10, 16'd10, 16'd10}) begin errors++; $display("FAIL basic_disp got %h", bus.xf_disp); end
        checks++; if (bus.xf_angle !== {16'd1, 16'd2, 16'd3}) begin errors++; $display("FAIL basic_angle got %h", bus.xf_angle); end
        wait_done(40, cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
        checks++; if (rd_n - rb !== 3) begin errors++; $display("FAIL basic_reads got %0d want 3", rd_n - rb); end
        checks++; if (wr_n - wb !== 3) begin errors++; $display("FAIL basic_writes got %0d want 3", wr_n - wb); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_log[rb+i] !== AW'(i)) begin errors++; $display("FAIL basic_rd_addr%0d got %0d want %0d", i, rd_log[rb+i], i); end
            checks++; if (wr_alog[wb+i] !== AW'(i)) begin errors++; $display("FAIL basic_wr_addr%0d got %0d want %0d", i, wr_alog[wb+i], i); end
            checks++; if (wr_dlog[wb+i] !== exp_w[i]) begin errors++; $display("FAIL basic_wr_data%0d got %h want %h", i, wr_dlog[wb+i], exp_w[i]); end
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_stall;
        int cyc, wb, ib, ub;
        ready_delay = 4; out_delay = 3;
        ram[0] = {16'h0100, 16'h0200, 16'h0300};
        ram[1] = {16'hFFFF, 16'h0000, 16'h7FFF};
        wb = wr_n; ib = iss_n; ub = unstable;
        do_start(7'd2, {16'd5, 16'd6, 16'd7}, '0);
        tick(); tick(); tick();
        disp = {16'hAAAA, 16'hBBBB, 16'hCCCC};
        tick();
        checks++; if (bus.xf_disp !== {16'd5, 16'd6, 16'd7}) begin errors++; $display("FAIL stall_disp_hold got %h", bus.xf_disp); end
        wait_done(100, cyc);
        checks++; if (cyc + 4 !== 25) begin errors++; $display("FAIL stall_latency got %0d want 25", cyc + 4); end
        checks++; if (iss_n - ib !== 2) begin errors++; $display("FAIL stall_issues got %0d want 2", iss_n - ib); end
        checks++; if (unstable - ub !== 0) begin errors++; $display("FAIL stall_in_data_stable got %0d want 0", unstable - ub); end
        checks++; if (wr_n - wb !== 2) begin errors++; $display("FAIL stall_writes got %0d want 2", wr_n - wb); end
        checks++; if (wr_dlog[wb] !== {16'h0105, 16'h0206, 16'h0307}) begin errors++; $display("FAIL stall_wr_data0 got %h", wr_dlog[wb]); end
        checks++; if (wr_dlog[wb+1] !== {16'h0004, 16'h0006, 16'h8006}) begin errors++; $display("FAIL stall_wr_data1 got %h", wr_dlog[wb+1]); end
        ready_delay = 0; out_delay = 0;
        tick();
    endtask

    task automatic test_zero_bad;
        int cyc, rb, wb;
        rb = rd_n; wb = wr_n;
        do_start(7'd0, '0, '0);
        wait_done(5, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", cyc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err got %b want 0", err); end
        tick();
        do_start(7'd101, '0, '0);
        wait_done(5, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL bad_latency got %0d want 1", cyc); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err got %b want 1", err); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_pulse got %b want 0", err); end
        checks++; if ((rd_n - rb) + (wr_n - wb) !== 0) begin errors++; $display("FAIL zero_bad_strobes got %0d want 0", (rd_n - rb) + (wr_n - wb)); end
    endtask

    task automatic test_max_count;
        int cyc, rb, wb;
        rb = rd_n; wb = wr_n;
        do_start(7'd100, {16'd1, 16'd1, 16'd1}, '0);
        wait_done(600, cyc);
        checks++; if (cyc !== 501) begin errors++; $display("FAIL max_latency got %0d want 501", cyc); end
        checks++; if (wr_n - wb !== 100) begin errors++; $display("FAIL max_writes got %0d want 100", wr_n - wb); end
        checks++; if (rd_log[rd_n-1] !== 7'd99) begin errors++; $display("FAIL max_last_rd got %0d want 99", rd_log[rd_n-1]); end
        checks++; if (wr_alog[wr_n-1] !== 7'd99) begin errors++; $display("FAIL max_last_wr got %0d want 99", wr_alog[wr_n-1]); end
        tick();
    endtask

    task automatic test_abort;
        int cyc, wb, db;
        wb = wr_n; db = done_n;
        do_start(7'd4, {16'd2, 16'd2, 16'd2}, '0);
        for (int i = 0; i < 9; i++) tick();
        abort = 1'b1;
        #1;
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_suppress got %b want 0", bus.mem_wr_en); end
        tick();
        abort = 1'b0;
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b want 1", aborted); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", busy); end
        tick();
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_pulse_len got %b want 0", aborted); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (done_n - db !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_n - db); end
        checks++; if (wr_n - wb !== 1) begin errors++; $display("FAIL abort_writes got %0d want 1", wr_n - wb); end
        checks++; if (wr_alog[wb] !== 7'd0) begin errors++; $display("FAIL abort_wr_addr got %0d want 0", wr_alog[wb]); end
        vcount = 7'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle got %b want 0", busy); end
        wb = wr_n;
        do_start(7'd2, {16'd2, 16'd2, 16'd2}, '0);
        wait_done(30, cyc);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL abort_restart_latency got %0d want 11", cyc); end
        checks++; if ({wr_alog[wb], wr_alog[wb+1]} !== {7'd0, 7'd1}) begin errors++; $display("FAIL abort_restart_addrs got %h want 0001", {wr_alog[wb], wr_alog[wb+1]}); end
        tick();
    endtask

    task automatic test_start_busy_reset;
        int cyc, wb, rb;
        logic [7:0] ctl;
        wb = wr_n;
        do_start(7'd3, {16'd3, 16'd3, 16'd3}, '0);
        for (int i = 0; i < 4; i++) tick();
        vcount = 7'd1; disp = {16'd9, 16'd9, 16'd9}; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (bus.xf_disp !== {16'd3, 16'd3, 16'd3}) begin errors++; $display("FAIL busy_start_disp got %h", bus.xf_disp); end
        wait_done(40, cyc);
        checks++; if (cyc + 5 !== 16) begin errors++; $display("FAIL busy_start_latency got %0d want 16", cyc + 5); end
        checks++; if (wr_n - wb !== 3) begin errors++; $display("FAIL busy_start_writes got %0d want 3", wr_n - wb); end
        tick();
        ready_delay = 4;
        do_start(7'd3, {16'd4, 16'd4, 16'd4}, {16'd5, 16'd5, 16'd5});
        tick(); tick();
        checks++; if (bus.xf_in_valid !== 1'b1) begin errors++; $display("FAIL rst_in_issue got %b want 1", bus.xf_in_valid); end
        rst_n = 1'b0;
        #1;
        ctl = {busy, done, err, aborted, bus.mem_rd_en, bus.mem_wr_en, bus.xf_in_valid, bus.xf_out_ready};
        checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL rst_mid_ctl got %h want 00", ctl); end
        checks++; if ({bus.xf_disp, bus.xf_angle, bus.xf_in_data} !== '0) begin errors++; $display("FAIL rst_mid_data got %h want 0", {bus.xf_disp, bus.xf_angle, bus.xf_in_data}); end
        #3 rst_n = 1'b1;
        ready_delay = 0;
        tick();
        rb = rd_n; wb = wr_n;
        do_start(7'd1, {16'd1, 16'd1, 16'd1}, '0);
        wait_done(20, cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL rst_fresh_latency got %0d want 6", cyc); end
        checks++; if (rd_log[rb] !== 7'd0) begin errors++; $display("FAIL rst_fresh_rd_addr got %0d want 0", rd_log[rb]); end
        checks++; if (wr_alog[wb] !== 7'd0) begin errors++; $display("FAIL rst_fresh_wr_addr got %0d want 0", wr_alog[wb]); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_bad();
        test_max_count();
        test_abort();
        test_start_busy_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vertex_transform_sequencer.md
Name: vertex_transform_sequencer

Overview:
- Controller that walks the vertex memory and sends each vertex through the transformation datapath (translation/rotation unit), one vertex at a time.
- It writes each transformed vertex back in place.
- It sits between the scene vertex RAM and the transformation unit, and is kicked by the frame/scene controller once per object update.
- It latches the displacement/angle configuration at start, so the datapath sees constant parameters for the whole pass.

Parameters:
- N_VERTS, 100, maximum number of vertices in the vertex RAM.
- ADDR_W, 7, vertex RAM address width (ceil(log2(N_VERTS))).
- CNT_W, 7, width of vert_count (ceil(log2(N_VERTS+1))).
- COORD_W, 16, width of one coordinate; a vertex is {x,y,z} = 3*COORD_W bits, x in MSBs.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  terminate the current pass.
- vert_count  in  CNT_W  number of vertices to process; latched on accepted start.
- disp_in  in  3*COORD_W  displacement {dx,dy,dz}; latched on accepted start.
- angle_in  in  3*COORD_W  Euler angles {ax,ay,az}; latched on accepted start.
- mem_rd_en  out  1  vertex RAM read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  3*COORD_W  read data, valid exactly 1 cycle after mem_rd_en.
- mem_wr_en  out  1  vertex RAM write strobe.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  3*COORD_W  write data.
- xf_disp  out  3*COORD_W  latched displacement to datapath.
- xf_angle  out  3*COORD_W  latched angles to datapath.
- xf_in_valid  out  1  vertex offered to datapath.
- xf_in_ready  in  1  datapath accepts vertex.
- xf_in_data  out  3*COORD_W  vertex to datapath.
- xf_out_valid  in  1  transformed vertex available.
- xf_out_ready  out  1  sequencer accepts result.
- xf_out_data  in  3*COORD_W  transformed vertex.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass completion (normal or error).
- err  out  1  one-cycle pulse, coincident with done, when vert_count > N_VERTS.
- aborted  out  1  one-cycle pulse when a pass is killed by abort.

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE and the index goes to 0.
  - All outputs read 0, including xf_disp/xf_angle and the data/address buses.
- States: IDLE, READ, WAIT_RD, ISSUE, WAIT_XF, WRITE, DONE.
- IDLE:
  - start=1 latches vert_count, disp_in and angle_in; busy=1 from the next cycle.
  - If vert_count==0 or vert_count>N_VERTS: go to DONE, with no memory or datapath access. err=1 in DONE only for vert_count>N_VERTS.
  - Otherwise: idx=0, go to READ.
- READ: mem_rd_en=1, mem_rd_addr=idx, for exactly 1 cycle; go to WAIT_RD.
- WAIT_RD: capture mem_rd_data into the xf_in_data register; go to ISSUE.
- ISSUE:
  - xf_in_valid=1; xf_in_data is held stable until xf_in_ready=1.
  - On the handshake cycle (valid and ready both high) go to WAIT_XF.
- WAIT_XF:
  - xf_out_ready=1.
  - On xf_out_valid=1, capture xf_out_data and go to WRITE.
  - xf_out_valid arriving while in ISSUE is not accepted (xf_out_ready=0 there).
- WRITE:
  - mem_wr_en=1, mem_wr_addr=idx, mem_wr_data=captured result, for 1 cycle.
  - If idx==count-1 go to DONE; else idx+1 and go to READ.
- DONE:
  - done=1 (and err if applicable) for 1 cycle; busy=0 in this cycle; next state IDLE.
  - start is ignored in DONE.
- Per-vertex throughput:
  - Minimum is 5 cycles (ready and out_valid high on the first cycle offered).
  - Pass latency, measured from the edge that samples start to done high, is 5*count+1 cycles.
- One outstanding vertex at a time. xf_disp/xf_angle are constant from the cycle after start until the next accepted start.
- start while busy: ignored. Parameters and count are unchanged.
- abort=1 in any non-IDLE state:
  - Next state IDLE, aborted=1 for 1 cycle, no done.
  - A WRITE coinciding with abort is suppressed (mem_wr_en=0); xf_in_valid drops immediately.
  - Vertices already written stay written.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, pass not started.
- Index is compared with the latched count and never wraps. The maximum address issued is N_VERTS-1.

Test Plan:
- count=3, ready=1, out_valid immediate, RAM[0..2]={1,2,3},{4,5,6},{7,8,9}, datapath adds disp={10,10,10} -> reads addr 0,1,2; writes {11,12,13},{14,15,16},{17,18,19} to 0,1,2; done high 16 cycles after the start edge; busy low in the done cycle.
- count=2, xf_in_ready held low 4 cycles, xf_out_valid delayed 3 cycles -> xf_in_data stable while stalled; no duplicate issue; exactly 2 writes; disp changed mid-pass leaves xf_disp unchanged.
- count=0 -> done pulse on the 2nd cycle after start, err=0, no rd/wr strobes. count=101 -> done and err together, no strobes.
- abort asserted in the WRITE cycle of vertex 1 (count=4) -> vertex 0 written, vertex 1 not written, aborted pulse, no done, state IDLE; a new start then runs normally.
- start pulsed during the pass, and rst_n pulsed low mid-ISSUE -> start ignored; on reset, all outputs 0 immediately (async) and a fresh start processes from address 0.
